// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake game-logic slice.
//   GRID_W / GRID_H : default playfield size in cells
//   CELL_SHIFT      : log2 of the cell size in pixels (4x4 blocks)
//   dir_t           : movement direction encoding
//   cell_t          : one grid cell {x, y}
//   state_t         : body tracker FSM states
package snake_pkg;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 2;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
    } cell_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CALC,
        ST_SCAN,
        ST_ERASE,
        ST_DRAW,
        ST_OVER
    } state_t;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Top-left pixel of a cell on the 160x120 display.
    function automatic logic [7:0] cell_px_x(input logic [5:0] cx);
        return {2'b00, cx} << CELL_SHIFT;
    endfunction

    function automatic logic [6:0] cell_px_y(input logic [4:0] cy);
        return {2'b00, cy} << CELL_SHIFT;
    endfunction

endpackage

// File: rtl/snake_body_tracker_seg_buf.sv
// snake_seg_buf: circular segment buffer, MAX_LEN entries of cell_t.
//   clk, resetn : clock, synchronous active-low reset
//   wr_en       : write wr_data at wr_addr on the clock edge
//   wr_addr     : write pointer (the new head slot)
//   wr_data     : cell to store
//   rd_addr     : combinational read pointer (scan / tail pointer)
//   rd_data     : cell stored at rd_addr
// Reset preloads the starting horizontal body at entries 0..INIT_LEN-1.
module snake_seg_buf
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 20,
    parameter int START_Y  = 15,
    parameter int PTR_W    = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  cell_t            wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output cell_t            rd_data
);

    cell_t mem [MAX_LEN];

    // NOTE: the array is reset on purpose: the initial body must exist in
    // the buffer before the first draw, so this cannot become plain RAM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    mem[i].x <= 6'(START_X - INIT_LEN + 1 + i);
                    mem[i].y <= 5'(START_Y);
                end else begin
                    mem[i] <= '0;
                end
            end
        end else if (wr_en) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/snake_body_tracker.sv
// snake_body_tracker: keeps the snake body and issues block draw/erase
// requests to the 4x4 block drawer on every game tick.
//   clk, resetn       : clock, synchronous active-low reset
//   step              : one-cycle game tick
//   dir_left/right/up/down : one-cycle direction pulses
//   grow              : food eaten, lengthen on the next move
//   req_valid/ready   : block request handshake
//   req_x, req_y      : block top-left pixel
//   req_erase         : 1 = black block, 0 = snake colour
//   length            : current segment count
//   busy              : FSM not idle
//   game_over         : wall or self collision happened
module snake_body_tracker #(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       step,
    input  logic       dir_left,
    input  logic       dir_right,
    input  logic       dir_up,
    input  logic       dir_down,
    input  logic       grow,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [7:0] req_x,
    output logic [6:0] req_y,
    output logic       req_erase,
    output logic [6:0] length,
    output logic       busy,
    output logic       game_over
);

    import snake_pkg::*;

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = 7;

    state_t           state;
    dir_t             dir;        // committed direction of the last move
    dir_t             dir_pend;   // last accepted pulse, committed on step
    logic             grow_pending;
    logic             grow_now;   // this move lengthens the snake
    cell_t            head_cell;  // copy of the head entry, avoids a 2nd read port
    cell_t            new_head;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] scan_cnt;   // INIT: transfers done, SCAN: entries left

    cell_t            rd_data;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    dir_t             pulse_dir;
    logic             pulse_any;
    logic             wall_hit;
    cell_t            calc_head;
    logic             grow_take;
    logic             scan_hit;
    logic             scan_last;
    logic             enter_draw;

    snake_seg_buf #(
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN),
        .START_X  (START_X),
        .START_Y  (START_Y),
        .PTR_W    (PTR_W)
    ) u_seg_buf (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (new_head),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pulse_any = dir_left | dir_right | dir_up | dir_down;
        pulse_dir = DIR_DOWN;
        if (dir_left)       pulse_dir = DIR_LEFT;
        else if (dir_right) pulse_dir = DIR_RIGHT;
        else if (dir_up)    pulse_dir = DIR_UP;
    end

    // Next head and wall test use the pending direction, which becomes the
    // committed one in the same CALC cycle.
    always_comb begin
        wall_hit  = 1'b0;
        calc_head = head_cell;
        unique case (dir_pend)
            DIR_LEFT: begin
                wall_hit    = (head_cell.x == 6'd0);
                calc_head.x = head_cell.x - 6'd1;
            end
            DIR_RIGHT: begin
                wall_hit    = (head_cell.x == 6'(GRID_W - 1));
                calc_head.x = head_cell.x + 6'd1;
            end
            DIR_UP: begin
                wall_hit    = (head_cell.y == 5'd0);
                calc_head.y = head_cell.y - 5'd1;
            end
            DIR_DOWN: begin
                wall_hit    = (head_cell.y == 5'(GRID_H - 1));
                calc_head.y = head_cell.y + 5'd1;
            end
        endcase
    end

    assign grow_take = grow_pending && (length < LEN_W'(MAX_LEN));
    assign scan_hit  = (rd_data == new_head);
    assign scan_last = (scan_cnt == LEN_W'(1));

    // The new head is written and its draw request loaded either at the end
    // of a growing scan or when the tail erase is accepted.
    assign enter_draw = (state == ST_SCAN && !scan_hit && scan_last && grow_now)
                     || (state == ST_ERASE && req_valid && req_ready);
    assign wr_en      = enter_draw;
    assign wr_addr    = head_ptr + PTR_W'(1);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_INIT;
            dir          <= DIR_RIGHT;
            dir_pend     <= DIR_RIGHT;
            grow_pending <= 1'b0;
            grow_now     <= 1'b0;
            head_cell    <= '{x: 6'(START_X), y: 5'(START_Y)};
            new_head     <= '0;
            head_ptr     <= PTR_W'(INIT_LEN - 1);
            tail_ptr     <= '0;
            rd_ptr       <= '0;
            scan_cnt     <= '0;
            length       <= LEN_W'(INIT_LEN);
            req_valid    <= 1'b0;
            req_x        <= '0;
            req_y        <= '0;
            req_erase    <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            if (state != ST_OVER) begin
                if (pulse_any && pulse_dir != reverse_dir(dir)) begin
                    dir_pend <= pulse_dir;
                end
                if (grow) begin
                    grow_pending <= 1'b1;
                end
            end

            unique case (state)
                ST_INIT: begin
                    // Streams entries tail to head, keeping req_valid high
                    // between back-to-back transfers.
                    if (!req_valid || req_ready) begin
                        if (req_valid && scan_cnt == LEN_W'(INIT_LEN - 1)) begin
                            req_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            if (req_valid) begin
                                scan_cnt <= scan_cnt + LEN_W'(1);
                            end
                            req_valid <= 1'b1;
                            req_x     <= cell_px_x(rd_data.x);
                            req_y     <= cell_px_y(rd_data.y);
                            req_erase <= 1'b0;
                            rd_ptr    <= rd_ptr + PTR_W'(1);
                        end
                    end
                end

                ST_IDLE: begin
                    if (step) begin
                        state <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    dir <= dir_pend;
                    if (wall_hit) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        new_head     <= calc_head;
                        grow_now     <= grow_take;
                        // A grow arriving in this very cycle stays pending.
                        grow_pending <= grow;
                        // A vacating tail is excluded from the scan.
                        rd_ptr       <= grow_take ? tail_ptr : tail_ptr + PTR_W'(1);
                        scan_cnt     <= grow_take ? length : length - LEN_W'(1);
                        state        <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (scan_hit) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else if (scan_last) begin
                        if (!grow_now) begin
                            rd_ptr <= tail_ptr;
                            state  <= ST_ERASE;
                        end
                    end else begin
                        rd_ptr   <= rd_ptr + PTR_W'(1);
                        scan_cnt <= scan_cnt - LEN_W'(1);
                    end
                end

                ST_ERASE: begin
                    if (!req_valid) begin
                        req_valid <= 1'b1;
                        req_x     <= cell_px_x(rd_data.x);
                        req_y     <= cell_px_y(rd_data.y);
                        req_erase <= 1'b1;
                    end else if (req_ready) begin
                        tail_ptr <= tail_ptr + PTR_W'(1);
                    end
                end

                ST_DRAW: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                ST_OVER: begin
                    req_valid <= 1'b0;
                    game_over <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (enter_draw) begin
                head_ptr  <= wr_addr;
                head_cell <= new_head;
                length    <= length + LEN_W'(grow_now);
                req_valid <= 1'b1;
                req_x     <= cell_px_x(new_head.x);
                req_y     <= cell_px_y(new_head.y);
                req_erase <= 1'b0;
                state     <= ST_DRAW;
            end
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Self-checking bench for snake_body_tracker: a queue-based body model
// predicts every block request; requests are compared as the DUT hands
// them over. A second instance built with MAX_LEN=4 covers the full buffer.
module tb_snake_body_tracker;

    import snake_pkg::*;

    localparam int MAX_LEN  = 64;
    localparam int INIT_LEN = 3;
    localparam int START_X  = 20;
    localparam int START_Y  = 15;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       erase;
    } req_t;

    logic       clk = 1'b0;
    logic       resetn, step, dir_left, dir_right, dir_up, dir_down, grow;
    logic       req_valid, req_ready, req_erase, busy, game_over;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [6:0] length;

    logic       s_resetn, s_step, s_grow, s_valid, s_erase, s_busy, s_game_over;
    logic       s_ready = 1'b1;
    logic [7:0] s_x;
    logic [6:0] s_y;
    logic [6:0] s_length;
    int         s_erase_cnt = 0;

    int    n_vec = 0;
    int    n_bad = 0;

    cell_t body[$];
    req_t  exp_q[$];
    dir_t  m_dir, m_pend;
    bit    m_grow, m_over;

    always #5 clk = ~clk;

    snake_body_tracker #(
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .GRID_W(40), .GRID_H(30),
        .START_X(START_X), .START_Y(START_Y)
    ) u_dut (
        .clk(clk), .resetn(resetn), .step(step),
        .dir_left(dir_left), .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down),
        .grow(grow), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_erase(req_erase),
        .length(length), .busy(busy), .game_over(game_over)
    );

    snake_body_tracker #(
        .MAX_LEN(4), .INIT_LEN(3), .GRID_W(40), .GRID_H(30),
        .START_X(START_X), .START_Y(START_Y)
    ) u_small (
        .clk(clk), .resetn(s_resetn), .step(s_step),
        .dir_left(1'b0), .dir_right(1'b0), .dir_up(1'b0), .dir_down(1'b0),
        .grow(s_grow), .req_valid(s_valid), .req_ready(s_ready),
        .req_x(s_x), .req_y(s_y), .req_erase(s_erase),
        .length(s_length), .busy(s_busy), .game_over(s_game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic req_t mk_req(input cell_t c, input bit e);
        return '{x: 8'(int'(c.x) * 4), y: 7'(int'(c.y) * 4), erase: e};
    endfunction

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            DIR_UP:    return DIR_DOWN;
            default:   return DIR_UP;
        endcase
    endfunction

    task automatic model_reset();
        cell_t c;
        body.delete();
        exp_q.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            c.x = 6'(START_X - INIT_LEN + 1 + i);
            c.y = 5'(START_Y);
            body.push_back(c);
            exp_q.push_back(mk_req(c, 1'b0));
        end
        m_dir  = DIR_RIGHT;
        m_pend = DIR_RIGHT;
        m_grow = 1'b0;
        m_over = 1'b0;
    endtask

    task automatic model_step();
        cell_t h, nh;
        int    nx, ny;
        bit    g;
        if (m_over) return;
        m_dir = m_pend;
        h  = body[body.size() - 1];
        nx = int'(h.x);
        ny = int'(h.y);
        case (m_dir)
            DIR_LEFT:  nx--;
            DIR_RIGHT: nx++;
            DIR_UP:    ny--;
            default:   ny++;
        endcase
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            m_over = 1'b1;
            return;
        end
        nh.x   = 6'(nx);
        nh.y   = 5'(ny);
        g      = m_grow && (body.size() < MAX_LEN);
        m_grow = 1'b0;
        for (int i = (g ? 0 : 1); i < body.size(); i++) begin
            if (body[i] == nh) begin
                m_over = 1'b1;
                return;
            end
        end
        if (!g) begin
            exp_q.push_back(mk_req(body[0], 1'b1));
            void'(body.pop_front());
        end
        exp_q.push_back(mk_req(nh, 1'b0));
        body.push_back(nh);
    endtask

    // ---------------- request monitor ----------------
    always @(negedge clk) begin
        req_t cur;
        cur = '{x: req_x, y: req_y, erase: req_erase};
        if (resetn && req_valid) begin
            check("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                if (req_ready) begin
                    check("req_data", 32'(cur), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end else begin
                    check("req_hold", 32'(cur), 32'(exp_q[0]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_resetn && s_valid && s_ready && s_erase) s_erase_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_settle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = !busy || game_over;
        end
        check({tag, "_settle"}, 32'(done), 32'd1);
        check({tag, "_len"}, 32'(length), 32'(body.size()));
        check({tag, "_over"}, 32'(game_over), 32'(m_over));
        tick();
    endtask

    task automatic pulse_dir(input dir_t d);
        case (d)
            DIR_LEFT:  dir_left  = 1'b1;
            DIR_RIGHT: dir_right = 1'b1;
            DIR_UP:    dir_up    = 1'b1;
            default:   dir_down  = 1'b1;
        endcase
        if (!m_over && d != opposite(m_dir)) m_pend = d;
        tick();
        {dir_left, dir_right, dir_up, dir_down} = '0;
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        if (!m_over) m_grow = 1'b1;
        tick();
        grow = 1'b0;
    endtask

    task automatic do_step(input string tag);
        step = 1'b1;
        model_step();
        tick();
        step = 1'b0;
        wait_settle(tag);
    endtask

    task automatic wait_small(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = !s_busy;
        end
        check({tag, "_settle"}, 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        resetn = 1'b0; step = 1'b0; grow = 1'b0; req_ready = 1'b1;
        {dir_left, dir_right, dir_up, dir_down} = '0;
        s_resetn = 1'b0; s_step = 1'b0; s_grow = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_valid", 32'(req_valid), 32'd0);
        check("rst_x", 32'(req_x), 32'd0);
        check("rst_y", 32'(req_y), 32'd0);
        check("rst_erase", 32'(req_erase), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_len", 32'(length), 32'(INIT_LEN));
        check("rst_busy", 32'(busy), 32'd1);
        resetn = 1'b1;
        wait_settle("init");
        check("init_idle", 32'(busy), 32'd0);

        do_step("plain");
        pulse_dir(DIR_LEFT);
        do_step("reverse");
        pulse_grow();
        do_step("grow");

        // Drawer stalls during the erase; a step arriving meanwhile is dropped.
        req_ready = 1'b0;
        step = 1'b1;
        model_step();
        tick();
        step = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = req_valid;
        end
        check("stall_valid_rise", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step = (i == 2);
            tick();
            check("stall_valid", 32'(req_valid), 32'd1);
        end
        step = 1'b0;
        req_ready = 1'b1;
        wait_settle("stall");
        repeat (4) tick();
        check("stall_dropped", 32'(busy), 32'd0);

        // Square loop: entering the vacating tail is legal, entering it
        // while growing is a collision.
        pulse_dir(DIR_UP);    do_step("loop_up");
        pulse_dir(DIR_LEFT);  do_step("loop_left");
        pulse_dir(DIR_DOWN);  do_step("loop_tail");
        pulse_dir(DIR_RIGHT);
        pulse_grow();
        do_step("loop_body");
        check("loop_body_over", 32'(game_over), 32'd1);
        do_step("over_ignore1");
        pulse_grow();
        do_step("over_ignore2");
        check("over_queue", 32'(exp_q.size()), 32'd0);

        // Run into the right wall.
        resetn = 1'b0;
        model_reset();
        tick();
        resetn = 1'b1;
        wait_settle("reinit");
        for (int i = 0; i < GRID_W - 1 - START_X; i++) do_step("to_wall");
        check("pre_wall_over", 32'(game_over), 32'd0);
        do_step("wall");
        check("wall_over", 32'(game_over), 32'd1);
        do_step("wall_ignore");
        check("wall_queue", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a stalled handshake.
        resetn = 1'b0;
        model_reset();
        tick();
        resetn = 1'b1;
        wait_settle("reinit2");
        req_ready = 1'b0;
        step = 1'b1;
        model_step();
        tick();
        step = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = req_valid;
        end
        check("midhs_valid_rise", 32'(seen), 32'd1);
        resetn = 1'b0;
        model_reset();
        tick();
        check("midhs_drop", 32'(req_valid), 32'd0);
        req_ready = 1'b1;
        resetn = 1'b1;
        wait_settle("midhs_init");

        // MAX_LEN=4 build: the second grow is discarded and the tail moves.
        s_resetn = 1'b1;
        wait_small("s_init");
        check("s_len_init", 32'(s_length), 32'd3);
        s_grow = 1'b1; tick(); s_grow = 1'b0;
        s_step = 1'b1; tick(); s_step = 1'b0;
        wait_small("s_grow1");
        check("s_len_grow1", 32'(s_length), 32'd4);
        check("s_erase_grow1", 32'(s_erase_cnt), 32'd0);
        s_grow = 1'b1; tick(); s_grow = 1'b0;
        s_step = 1'b1; tick(); s_step = 1'b0;
        wait_small("s_grow2");
        check("s_len_full", 32'(s_length), 32'd4);
        check("s_erase_full", 32'(s_erase_cnt), 32'd1);
        check("s_over", 32'(s_game_over), 32'd0);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
